// File: rtl/rx_comma_aligner.sv
// Serial-to-10b deserialiser that finds and tracks the K28.5 comma boundary.
// Bit 'a' arrives first and lands in symbol10_o[0].
//
// state  | meaning
// HUNT   | searching every bit position for a comma
// CHECK  | boundary chosen, collecting confirming aligned commas
// LOCKED | boundary confirmed, data symbols delivered at fixed phase
module rx_comma_aligner #(
    parameter int COMMA_CONFIRM = 2,
    parameter int TIMEOUT_SYMS  = 16
) (
    input  logic       clkRx_i,
    input  logic       rst_i,
    input  logic       enb_i,
    input  logic       serialIn_i,
    output logic [9:0] symbol10_o,
    output logic       symValid_o,
    output logic       k285Det_o,
    output logic       locked_o,
    output logic       alignErr_o
);
    localparam int CW = $clog2(COMMA_CONFIRM + 1);
    localparam int TW = $clog2(TIMEOUT_SYMS + 1);
    localparam logic [CW-1:0] CONF_MAX  = CW'(COMMA_CONFIRM);
    localparam logic [CW-1:0] CONF_LAST = CW'(COMMA_CONFIRM - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_SYMS - 1);
    localparam logic [9:0]    K285_RDN  = 10'h17C;
    localparam logic [9:0]    K285_RDP  = 10'h283;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [9:0]      sr_q, sr_d;
    logic [9:0]      sym_q, sym_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   conf_q, conf_d;
    logic [TW-1:0]   to_q, to_d;
    logic            valid_q, valid_d;
    logic            k_q, k_d;
    logic            err_q, err_d;

    logic [9:0]      win;
    logic            match;
    logic            boundary;

    assign win      = {serialIn_i, sr_q[9:1]};
    assign match    = (win == K285_RDN) || (win == K285_RDP);
    assign boundary = (bit_cnt_q == 4'd9);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        sym_d     = sym_q;
        bit_cnt_d = bit_cnt_q;
        conf_d    = conf_q;
        to_d      = to_q;
        valid_d   = 1'b0;
        k_d       = 1'b0;
        err_d     = 1'b0;
        if (enb_i) begin
            sr_d      = win;
            bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
            // A comma anywhere in HUNT, or off-boundary once aligned, (re)sets the phase.
            if (match && (state_q == HUNT || !boundary)) begin
                sym_d     = win;
                valid_d   = 1'b1;
                k_d       = 1'b1;
                err_d     = (state_q != HUNT);
                bit_cnt_d = 4'd0;
                conf_d    = CW'(1);
                to_d      = '0;
                state_d   = (COMMA_CONFIRM == 1) ? LOCKED : CHECK;
            end else if (state_q != HUNT && boundary) begin
                sym_d   = win;
                valid_d = 1'b1;
                k_d     = match;
                if (match) begin
                    to_d = '0;
                    if (conf_q != CONF_MAX) conf_d = conf_q + CW'(1);
                    if (state_q == CHECK && conf_q == CONF_LAST) state_d = LOCKED;
                end else if (state_q == CHECK) begin
                    if (to_q == TO_LAST) begin
                        state_d = HUNT;
                        conf_d  = '0;
                        to_d    = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clkRx_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            sym_q     <= '0;
            bit_cnt_q <= '0;
            conf_q    <= '0;
            to_q      <= '0;
            valid_q   <= 1'b0;
            k_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            sym_q     <= sym_d;
            bit_cnt_q <= bit_cnt_d;
            conf_q    <= conf_d;
            to_q      <= to_d;
            valid_q   <= valid_d;
            k_q       <= k_d;
            err_q     <= err_d;
        end
    end

    assign symbol10_o = sym_q;
    assign symValid_o = valid_q;
    assign k285Det_o  = k_q;
    assign alignErr_o = err_q;
    assign locked_o   = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Directed bench for rx_comma_aligner: lock, realign, timeout, enable gap and mid-symbol reset.
module tb_rx_comma_aligner;
    logic       clk = 1'b0;
    logic       rst, enb, ser;
    logic [9:0] symbol10;
    logic       sym_valid, k285, locked, align_err;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [9:0] q_sym[$];
    logic       q_k[$];
    int         err_cnt = 0;

    always #5 clk = ~clk;

    rx_comma_aligner #(.COMMA_CONFIRM(2), .TIMEOUT_SYMS(16)) dut (
        .clkRx_i    (clk),
        .rst_i      (rst),
        .enb_i      (enb),
        .serialIn_i (ser),
        .symbol10_o (symbol10),
        .symValid_o (sym_valid),
        .k285Det_o  (k285),
        .locked_o   (locked),
        .alignErr_o (align_err)
    );

    always @(posedge clk) begin
        #1;
        if (sym_valid === 1'b1) begin
            q_sym.push_back(symbol10);
            q_k.push_back(k285);
        end
        if (align_err === 1'b1) err_cnt++;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        enb = 1'b1;
        ser = b;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enb = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; enb = 1'b0; ser = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q_sym.delete(); q_k.delete(); err_cnt = 0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++; if (symbol10 !== 10'h000) begin tests_failed++; $display("FAIL rst_symbol: got %h expected %h", symbol10, 10'h000); end
        tests_run++; if (sym_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", sym_valid); end
        tests_run++; if (k285 !== 1'b0) begin tests_failed++; $display("FAIL rst_k: got %b expected 0", k285); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rst_locked: got %b expected 0", locked); end
        tests_run++; if (align_err !== 1'b0) begin tests_failed++; $display("FAIL rst_alignerr: got %b expected 0", align_err); end
        for (int i = 0; i < 30; i++) send_bit(1'b0);
        hold(1);
        tests_run++; if (q_sym.size() !== 0) begin tests_failed++; $display("FAIL zeros_pulses: got %0d expected 0", q_sym.size()); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL zeros_locked: got %b expected 0", locked); end
        tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL zeros_alignerr: got %0d expected 0", err_cnt); end
        tests_run++; if (symbol10 !== 10'h000) begin tests_failed++; $display("FAIL zeros_symbol: got %h expected 000", symbol10); end
    endtask

    task automatic test_lock_sequence;
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_sym(10'h17C);
        send_sym(10'h274);
        hold(2);
        tests_run++; if (q_sym.size() !== 2) begin tests_failed++; $display("FAIL lock_count2: got %0d expected 2", q_sym.size()); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early: got %b expected 0", locked); end
        send_sym(10'h283);
        hold(2);
        tests_run++; if (q_sym.size() !== 3) begin tests_failed++; $display("FAIL lock_count3: got %0d expected 3", q_sym.size()); end
        tests_run++; if (q_sym[0] !== 10'h17C || q_k[0] !== 1'b1) begin tests_failed++; $display("FAIL lock_sym0: got %h k=%b expected 17c k=1", q_sym[0], q_k[0]); end
        tests_run++; if (q_sym[1] !== 10'h274 || q_k[1] !== 1'b0) begin tests_failed++; $display("FAIL lock_sym1: got %h k=%b expected 274 k=0", q_sym[1], q_k[1]); end
        tests_run++; if (q_sym[2] !== 10'h283 || q_k[2] !== 1'b1) begin tests_failed++; $display("FAIL lock_sym2: got %h k=%b expected 283 k=1", q_sym[2], q_k[2]); end
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_locked: got %b expected 1", locked); end
        tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL lock_alignerr: got %0d expected 0", err_cnt); end
    endtask

    // Continues from the locked state left by test_lock_sequence.
    task automatic test_realign;
        q_sym.delete(); q_k.delete(); err_cnt = 0;
        send_sym(10'h17C);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_sym(10'h17C);
        hold(2);
        tests_run++; if (q_sym.size() !== 3) begin tests_failed++; $display("FAIL realign_count: got %0d expected 3", q_sym.size()); end
        tests_run++; if (q_sym[1] !== 10'h3C0 || q_k[1] !== 1'b0) begin tests_failed++; $display("FAIL realign_data: got %h k=%b expected 3c0 k=0", q_sym[1], q_k[1]); end
        tests_run++; if (q_sym[2] !== 10'h17C || q_k[2] !== 1'b1) begin tests_failed++; $display("FAIL realign_sym: got %h k=%b expected 17c k=1", q_sym[2], q_k[2]); end
        tests_run++; if (err_cnt !== 1) begin tests_failed++; $display("FAIL realign_err: got %0d expected 1", err_cnt); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL realign_unlock: got %b expected 0", locked); end
        send_sym(10'h17C);
        hold(2);
        tests_run++; if (q_sym.size() !== 4 || q_sym[3] !== 10'h17C) begin tests_failed++; $display("FAIL relock_sym: got n=%0d %h expected n=4 17c", q_sym.size(), q_sym[3]); end
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL relock_locked: got %b expected 1", locked); end
        send_sym(10'h274);
        hold(2);
        tests_run++; if (q_sym.size() !== 5 || q_sym[4] !== 10'h274 || q_k[4] !== 1'b0) begin tests_failed++; $display("FAIL newphase_data: got n=%0d %h k=%b expected n=5 274 k=0", q_sym.size(), q_sym[4], q_k[4]); end
        tests_run++; if (err_cnt !== 1) begin tests_failed++; $display("FAIL newphase_err: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_timeout;
        do_reset();
        send_sym(10'h17C);
        for (int i = 0; i < 16; i++) send_sym(10'h000);
        hold(1);
        tests_run++; if (q_sym.size() !== 17) begin tests_failed++; $display("FAIL to_count: got %0d expected 17", q_sym.size()); end
        tests_run++; if (q_k[0] !== 1'b1 || q_sym[16] !== 10'h000 || q_k[16] !== 1'b0) begin tests_failed++; $display("FAIL to_syms: got k0=%b s16=%h k16=%b expected 1 000 0", q_k[0], q_sym[16], q_k[16]); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL to_locked: got %b expected 0", locked); end
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        hold(1);
        tests_run++; if (q_sym.size() !== 17) begin tests_failed++; $display("FAIL to_hunt_quiet: got %0d expected 17", q_sym.size()); end
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_sym(10'h17C);
        hold(1);
        tests_run++; if (q_sym.size() !== 18 || q_sym[17] !== 10'h17C) begin tests_failed++; $display("FAIL to_rehunt: got n=%0d %h expected n=18 17c", q_sym.size(), q_sym[17]); end
        tests_run++; if (err_cnt !== 0 || locked !== 1'b0) begin tests_failed++; $display("FAIL to_rehunt_flags: got err=%0d locked=%b expected 0 0", err_cnt, locked); end
    endtask

    task automatic test_enb_gap;
        logic [9:0] d;
        d = 10'h274;
        do_reset();
        send_sym(10'h17C);
        send_sym(10'h17C);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            enb = 1'b0;
            ser = i[0];
        end
        tests_run++; if (q_sym.size() !== 2) begin tests_failed++; $display("FAIL gap_pulses: got %0d expected 2", q_sym.size()); end
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL gap_locked: got %b expected 1", locked); end
        for (int i = 5; i < 10; i++) send_bit(d[i]);
        send_sym(10'h17C);
        hold(1);
        tests_run++; if (q_sym.size() !== 4) begin tests_failed++; $display("FAIL gap_count: got %0d expected 4", q_sym.size()); end
        tests_run++; if (q_sym[2] !== 10'h274 || q_k[2] !== 1'b0) begin tests_failed++; $display("FAIL gap_data: got %h k=%b expected 274 k=0", q_sym[2], q_k[2]); end
        tests_run++; if (q_sym[3] !== 10'h17C || q_k[3] !== 1'b1) begin tests_failed++; $display("FAIL gap_comma: got %h k=%b expected 17c k=1", q_sym[3], q_k[3]); end
        tests_run++; if (locked !== 1'b1 || err_cnt !== 0) begin tests_failed++; $display("FAIL gap_flags: got locked=%b err=%0d expected 1 0", locked, err_cnt); end
    endtask

    task automatic test_reset_mid_symbol;
        logic [9:0] d;
        d = 10'h274;
        do_reset();
        send_sym(10'h17C);
        send_sym(10'h17C);
        hold(1);
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_locked: got %b expected 1", locked); end
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        @(negedge clk);
        rst = 1'b1; enb = 1'b1; ser = d[5];
        @(negedge clk);
        rst = 1'b0; enb = 1'b0;
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rstmid_locked: got %b expected 0", locked); end
        tests_run++; if (symbol10 !== 10'h000 || sym_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_outputs: got %h v=%b expected 000 v=0", symbol10, sym_valid); end
        for (int i = 6; i < 10; i++) send_bit(d[i]);
        send_sym(10'h17C);
        hold(1);
        tests_run++; if (q_sym.size() !== 3 || q_sym[2] !== 10'h17C) begin tests_failed++; $display("FAIL rstmid_first: got n=%0d %h expected n=3 17c", q_sym.size(), q_sym[2]); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rstmid_one_comma: got %b expected 0", locked); end
        send_sym(10'h17C);
        hold(1);
        tests_run++; if (q_sym.size() !== 4 || locked !== 1'b1) begin tests_failed++; $display("FAIL rstmid_relock: got n=%0d locked=%b expected n=4 1", q_sym.size(), locked); end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; ser = 1'b0;
        test_reset();
        test_lock_sequence();
        test_realign();
        test_timeout();
        test_enb_gap();
        test_reset_mid_symbol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
        $fatal(1);
    end

endmodule
